// File: rtl/iobus_ctrl.sv
// Half-duplex tri-state bus controller with programmable turnaround gaps.
// Optional sticky bus-contention detector enabled by `define IOBUS_CONTENTION_CHECK_EN.
module iobus_ctrl #(
    parameter int WIDTH = 8,
    parameter int TURN  = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_valid,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ready,
    input  logic             rd_req,
    output logic             rd_ready,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic             dir,
`ifdef IOBUS_CONTENTION_CHECK_EN
    output logic             contention,
`endif
    inout  wire  [WIDTH-1:0] io
);

    localparam int CW = $clog2(TURN + 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] TURN_TX = 2'd1;
    localparam logic [1:0] TX      = 2'd2;
    localparam logic [1:0] TURN_RX = 2'd3;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic             oe_q;
    logic [WIDTH-1:0] tx_q;
    logic             accept;

    // Handshakes are masked during reset so nothing is accepted on a reset edge.
    assign wr_ready = !reset && (state == TX) && !rd_req;
    assign rd_ready = !reset && (state == IDLE) && rd_req;
    assign accept   = wr_valid && wr_ready;
    assign dir      = (state == TURN_TX) || (state == TX);
    assign io       = oe_q ? tx_q : {WIDTH{1'bz}};

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (!rd_req && wr_valid) begin
                    state_nxt = TURN_TX;
                    cnt_nxt   = CW'(TURN);
                end
            end
            TURN_TX: begin
                if (cnt <= CW'(1)) begin
                    state_nxt = TX;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            TX: begin
                // Any cycle without an accept ends the burst, which is how a read preempts.
                if (!accept) begin
                    state_nxt = TURN_RX;
                    cnt_nxt   = CW'(TURN);
                end
            end
            TURN_RX: begin
                if (cnt <= CW'(1)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            oe_q     <= 1'b0;
            tx_q     <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            oe_q     <= accept;
            if (accept) begin
                tx_q <= wr_data;
            end
            rd_valid <= rd_ready;
            if (rd_ready) begin
                rd_data <= io;
            end
        end
    end

`ifdef IOBUS_CONTENTION_CHECK_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            contention <= 1'b0;
        end else if (oe_q && (io != tx_q)) begin
            contention <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_iobus_ctrl.sv
// Scoreboard bench for iobus_ctrl: bus words and read samples are queued at handshake
// and compared when they appear on io / rd_data. Define IOBUS_CONTENTION_CHECK_EN for the detector.
module tb_iobus_ctrl;
    localparam int WIDTH = 8;
    localparam int TURN  = 2;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             wr_valid = 1'b0;
    logic [WIDTH-1:0] wr_data = '0;
    logic             rd_req = 1'b0;
    logic             wr_ready;
    logic             rd_ready;
    logic             rd_valid;
    logic [WIDTH-1:0] rd_data;
    logic             dir;
`ifdef IOBUS_CONTENTION_CHECK_EN
    logic             contention;
`endif
    logic             ext_en = 1'b0;
    logic [WIDTH-1:0] ext_val = '0;
    wire  [WIDTH-1:0] io;

    assign io = ext_en ? ext_val : {WIDTH{1'bz}};

    iobus_ctrl #(.WIDTH(WIDTH), .TURN(TURN)) dut (
        .clock      (clock),
        .reset      (reset),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .rd_req     (rd_req),
        .rd_ready   (rd_ready),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .dir        (dir),
`ifdef IOBUS_CONTENTION_CHECK_EN
        .contention (contention),
`endif
        .io         (io)
    );

    always #5 clock = ~clock;

    int               n_checks = 0;
    int               n_errors = 0;
    logic [WIDTH-1:0] wq[$];
    logic [WIDTH-1:0] rq[$];
    logic [WIDTH-1:0] mexp;
    logic             drv_pend = 1'b0;
    logic             rd_pend = 1'b0;
    logic             mon_en = 1'b0;
    logic             io_skip = 1'b0;
    int               acc_cnt = 0;
    int               it;
    int               t;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic sample();
        @(negedge clock);
    endtask

    // Scoreboard monitor: each accepted word must appear on io the next cycle only.
    always @(negedge clock) begin
        if (mon_en) begin
            if (drv_pend) begin
                chk("sb_wq_depth", wq.size(), 1);
                if (wq.size() > 0) begin
                    mexp = wq.pop_front();
                    if (!io_skip) chk("io_word", io, mexp);
                end
                chk("io_oe", dut.oe_q, 1);
            end else begin
                chk("io_release", dut.oe_q, 0);
            end
            if (dut.oe_q) chk("dir_when_driven", dir, 1);
            if (rd_pend) begin
                chk("rd_valid_pulse", rd_valid, 1);
                chk("sb_rq_depth", rq.size(), 1);
                if (rq.size() > 0) begin
                    mexp = rq.pop_front();
                    chk("rd_data_sb", rd_data, mexp);
                end
            end else begin
                chk("rd_valid_quiet", rd_valid, 0);
            end
            drv_pend = wr_valid && wr_ready && !reset;
            if (drv_pend) wq.push_back(wr_data);
            rd_pend = rd_ready && !reset;
            if (rd_pend) rq.push_back(ext_en ? ext_val : '0);
        end
    end

    task automatic write_burst(input logic [WIDTH-1:0] base, input int n, output int iters);
        int   k;
        logic acc;
        k = 0;
        iters = 0;
        wr_data = base;
        wr_valid = 1'b1;
        while (k < n && iters < 64) begin
            sample();
            acc = wr_ready;
            iters++;
            step();
            if (acc) begin
                k++;
                acc_cnt = k;
                if (k < n) wr_data = base + k[WIDTH-1:0];
                else wr_valid = 1'b0;
            end
        end
        chk("wr_burst_done", k, n);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        // Reset with both requests active
        reset = 1'b1; wr_valid = 1'b1; rd_req = 1'b1; wr_data = 8'h5A;
        for (int i = 0; i < 2; i++) begin
            step(); sample();
            chk("rst_dir", dir, 0);
            chk("rst_wr_ready", wr_ready, 0);
            chk("rst_rd_ready", rd_ready, 0);
            chk("rst_rd_valid", rd_valid, 0);
            chk("rst_rd_data", rd_data, 0);
            chk("rst_oe", dut.oe_q, 0);
            chk("rst_tx_q", dut.tx_q, 0);
        end
        step(); reset = 1'b0; wr_valid = 1'b0; rd_req = 1'b0; mon_en = 1'b1;

        // Single write A5, then a read of 3C issued in the last turnaround cycle
        step(); wr_valid = 1'b1; wr_data = 8'hA5;
        sample(); chk("w_c0_dir", dir, 0);
        for (int c = 1; c <= 2; c++) begin
            step(); sample();
            chk("w_turn_dir", dir, 1);
            chk("w_turn_wr_ready", wr_ready, 0);
        end
        step(); sample();
        chk("w_c3_wr_ready", wr_ready, 1);
        chk("w_c3_dir", dir, 1);
        step(); wr_valid = 1'b0;
        sample();
        chk("w_c4_io", io, 8'hA5);
        chk("w_c4_dir", dir, 1);
        for (int c = 5; c <= 6; c++) begin
            step();
            if (c == 6) begin rd_req = 1'b1; ext_en = 1'b1; ext_val = 8'h3C; end
            sample();
            chk("w_turnrx_dir", dir, 0);
            if (c == 6) chk("turnrx_rd_ready", rd_ready, 0);
        end
        step(); sample();
        chk("idle_rd_ready", rd_ready, 1);
        chk("idle_rd_dir", dir, 0);
        step(); rd_req = 1'b0; ext_en = 1'b0;
        sample();
        chk("idle_rd_valid", rd_valid, 1);
        chk("idle_rd_data", rd_data, 8'h3C);

        // Back-to-back burst 01..04
        step();
        acc_cnt = 0;
        write_burst(8'h01, 4, it);
        chk("burst_iters", it, 3 + TURN + 2);
        sample(); chk("burst_last_dir", dir, 1);
        step(); sample(); chk("burst_rx1_dir", dir, 0);
        step(); sample(); chk("burst_rx2_dir", dir, 0);
        step(); sample(); chk("burst_idle_dir", dir, 0);

        // Read preempts a five-word burst at the third word
        step();
        acc_cnt = 0;
        fork
            write_burst(8'h10, 5, it);
            begin : rdr
                int w;
                w = 0;
                while (acc_cnt != 2 && w < 64) begin @(posedge clock); #2; w++; end
                chk("preempt_sync", acc_cnt, 2);
                rd_req = 1'b1;
                sample(); chk("preempt_wr_ready", wr_ready, 0);
                @(posedge clock); #2; ext_en = 1'b1; ext_val = 8'hC3;
                sample(); chk("preempt_rx1_dir", dir, 0); chk("preempt_rx1_rd_ready", rd_ready, 0);
                @(posedge clock); #2;
                sample(); chk("preempt_rx2_rd_ready", rd_ready, 0);
                @(posedge clock); #2;
                sample(); chk("preempt_rd_ready", rd_ready, 1);
                @(posedge clock); #2; rd_req = 1'b0; ext_en = 1'b0;
                sample(); chk("preempt_rd_data", rd_data, 8'hC3); chk("preempt_idle_dir", dir, 0);
                @(posedge clock); #2;
                sample(); chk("resume_dir", dir, 1);
            end
        join
        chk("preempt_iters", it, 15);
        for (int i = 0; i < 4; i++) step();

        // Simultaneous read and write request in IDLE: read first
        rd_req = 1'b1; wr_valid = 1'b1; wr_data = 8'h77; ext_en = 1'b1; ext_val = 8'hE1;
        sample();
        chk("both_rd_ready", rd_ready, 1);
        chk("both_wr_ready", wr_ready, 0);
        chk("both_dir", dir, 0);
        step(); rd_req = 1'b0; ext_en = 1'b0;
        sample(); chk("both_idle_dir", dir, 0); chk("both_rd_data", rd_data, 8'hE1);
        step(); sample(); chk("both_turn_tx_dir", dir, 1);
        t = 0;
        while (!wr_ready && t < 20) begin step(); sample(); t++; end
        chk("both_wait", t, TURN);
        step(); wr_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();

        // Reset in the middle of a burst
        wr_valid = 1'b1; wr_data = 8'hE7;
        t = 0;
        sample();
        while (!wr_ready && t < 20) begin step(); sample(); t++; end
        chk("midrst_ready_seen", wr_ready, 1);
        step(); reset = 1'b1;
        sample();
        step(); sample();
        chk("midrst_dir", dir, 0);
        chk("midrst_oe", dut.oe_q, 0);
        chk("midrst_wr_ready", wr_ready, 0);
        step(); reset = 1'b0; wr_valid = 1'b0;
        step(); sample(); chk("midrst_after_dir", dir, 0);

`ifdef IOBUS_CONTENTION_CHECK_EN
        step(); sample(); chk("cont_init", contention, 0);
        step(); wr_valid = 1'b1; wr_data = 8'hA5;
        t = 0;
        sample();
        while (!wr_ready && t < 20) begin step(); sample(); t++; end
        step(); wr_valid = 1'b0; io_skip = 1'b1;
        force io = 8'hFF;
        sample();
        step(); release io; io_skip = 1'b0;
        sample(); chk("cont_set", contention, 1);
        for (int i = 0; i < 3; i++) begin step(); sample(); chk("cont_sticky", contention, 1); end
        step(); reset = 1'b1;
        step(); reset = 1'b0;
        sample(); chk("cont_cleared", contention, 0);
`endif

        for (int i = 0; i < 3; i++) step();
        sample();
        chk("sb_wq_empty", wq.size(), 0);
        chk("sb_rq_empty", rq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
